// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: redirect input, I-cache request/response and fetch-buffer push.
// master = fetch stage, slave = surrounding back-end / cache / fetch buffer.
interface inst_fetch_if #(
    parameter int INST_FETCH_NUM = 4
);
    logic                          redirect_valid;
    logic [31:0]                   redirect_pc;
    logic                          icache_req_valid;
    logic [31:0]                   icache_req_addr;
    logic                          icache_req_ready;
    logic                          icache_resp_valid;
    logic [32*INST_FETCH_NUM-1:0]  icache_resp_data;
    logic [32*INST_FETCH_NUM-1:0]  insts_out_pc;
    logic [32*INST_FETCH_NUM-1:0]  insts_out_inst;
    logic [INST_FETCH_NUM-1:0]     insts_out_mask;
    logic                          insts_out_valid;
    logic                          fb_full;

    modport master (
        input  redirect_valid, redirect_pc,
        input  icache_req_ready, icache_resp_valid, icache_resp_data, fb_full,
        output icache_req_valid, icache_req_addr,
        output insts_out_pc, insts_out_inst, insts_out_mask, insts_out_valid
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output icache_req_ready, icache_resp_valid, icache_resp_data, fb_full,
        input  icache_req_valid, icache_req_addr,
        input  insts_out_pc, insts_out_inst, insts_out_mask, insts_out_valid
    );
endinterface

// File: rtl/inst_fetch.sv
// Fetch stage: one aligned N-instruction group request in flight; pushes the returned group
// in the response cycle, or holds it while the fetch buffer is full. Redirects squash it.
module inst_fetch #(
    parameter int          INST_FETCH_NUM = 4,
    parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
    input logic          clk,
    input logic          reset,
    inst_fetch_if.master fe
);
    localparam int          N         = INST_FETCH_NUM;
    localparam int          GRP_BITS  = $clog2(N * 4);
    localparam logic [31:0] GRP_BYTES = 32'(N * 4);
    localparam logic [31:0] GRP_MASK  = ~(GRP_BYTES - 32'd1);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DROP
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic [31:0]     req_addr_q, req_addr_d;
    logic            req_vld_q, req_vld_d;
    logic [32*N-1:0] hold_q, hold_d;

    logic [31:0]     redir_pc;
    logic [31:0]     req_base;
    logic [31:0]     req_off;
    logic [31:0]     seq_pc;
    logic            hs;
    logic            push;

    always_comb begin
        redir_pc = {fe.redirect_pc[31:2], 2'b00};
        req_base = req_pc_q & GRP_MASK;
        req_off  = (req_pc_q - req_base) >> 2;
        seq_pc   = req_base + GRP_BYTES;
        hs       = (state_q == ST_REQ) && req_vld_q && fe.icache_req_ready;
        // A redirect always wins over a push in the same cycle.
        push     = !fe.redirect_valid && !fe.fb_full &&
                   (((state_q == ST_WAIT) && fe.icache_resp_valid) || (state_q == ST_HOLD));
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        hold_d   = hold_q;
        case (state_q)
            ST_REQ: begin
                if (fe.redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = hs ? ST_DROP : ST_REQ;
                end else if (hs) begin
                    req_pc_d = pc_q;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fe.redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = fe.icache_resp_valid ? ST_REQ : ST_DROP;
                end else if (fe.icache_resp_valid) begin
                    if (!fe.fb_full) begin
                        pc_d    = seq_pc;
                        state_d = ST_REQ;
                    end else begin
                        hold_d  = fe.icache_resp_data;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (fe.redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = ST_REQ;
                end else if (!fe.fb_full) begin
                    pc_d    = seq_pc;
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (fe.redirect_valid) begin
                    pc_d = redir_pc;
                end
                if (fe.icache_resp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
        // Request outputs are registered so the REQ address already reflects the new pc.
        req_vld_d  = (state_d == ST_REQ);
        req_addr_d = pc_d & GRP_MASK;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            req_addr_q <= '0;
            req_vld_q  <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            req_addr_q <= req_addr_d;
            req_vld_q  <= req_vld_d;
            hold_q     <= hold_d;
        end
    end

    assign fe.icache_req_valid = req_vld_q;
    assign fe.icache_req_addr  = req_addr_q;
    assign fe.insts_out_valid  = push;

    // Group data is driven only while a push is happening; otherwise the outputs read zero.
    always_comb begin
        fe.insts_out_pc   = '0;
        fe.insts_out_inst = '0;
        fe.insts_out_mask = '0;
        if (push) begin
            fe.insts_out_inst = (state_q == ST_HOLD) ? hold_q : fe.icache_resp_data;
            for (int i = 0; i < N; i++) begin
                fe.insts_out_pc[32*i +: 32] = req_base + 32'(4 * i);
                fe.insts_out_mask[i]        = (32'(i) >= req_off);
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{GRP_BITS[0]};
endmodule
